// File: rtl/serial_slave.sv
// Bit-serial memory slave: LSB-first address/data capture into a MEM_DEPTH x DATA_W
// array, single-cycle write commit, and bit-serial read-back with master backpressure.
module serial_slave #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic read_en,
   input  logic write_en,
   input  logic master_valid,
   input  logic master_ready,
   input  logic rx_address,
   input  logic rx_data,
   input  logic rx_burst,
   output logic slave_ready,
   output logic slave_valid,
   output logic tx_data,
   output logic rx_done,
   output logic slave_tx_done
);

   localparam int CNT_W = $clog2(ADDR_W + 1);
   localparam int BIT_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      IDLE,
      RX,
      WRITE,
      TX,
      DONE
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_nxt;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] data_nxt;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_shift;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bit_idx;
   logic              write_mode;
   logic              beat;
   logic              unused_burst;

   assign beat         = master_valid & slave_ready;
   assign unused_burst = rx_burst;

   // Address/data register contents as they will be after a beat this cycle.
   always_comb begin
      addr_nxt = addr;
      data_nxt = data;
      if (state == IDLE) begin
         addr_nxt    = '0;
         addr_nxt[0] = rx_address;
         data_nxt    = '0;
         data_nxt[0] = rx_data & write_en;
      end else begin
         for (int unsigned k = 0; k < ADDR_W; k++) begin
            if (k == 32'(cnt)) addr_nxt[k] = rx_address;
         end
         if (write_mode) begin
            for (int unsigned k = 0; k < DATA_W; k++) begin
               if (k == 32'(cnt)) data_nxt[k] = rx_data;
            end
         end
      end
   end

   // On the final address beat the read word must come from the just-completed address.
   always_comb begin
      rd_addr  = (state == TX) ? addr : addr_nxt;
      rd_word  = mem[rd_addr];
      rd_shift = rd_word >> (bit_idx + 1'b1);
   end

   always_ff @(posedge clk) begin
      if (reset && state == WRITE) mem[addr] <= data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         addr          <= '0;
         data          <= '0;
         write_mode    <= 1'b0;
         slave_ready   <= 1'b0;
         slave_valid   <= 1'b0;
         tx_data       <= 1'b0;
         rx_done       <= 1'b0;
         slave_tx_done <= 1'b0;
      end else begin
         rx_done       <= 1'b0;
         slave_tx_done <= 1'b0;
         case (state)
            IDLE: begin
               slave_ready <= 1'b1;
               if (beat && (write_en || read_en)) begin
                  write_mode <= write_en;
                  addr       <= addr_nxt;
                  data       <= data_nxt;
                  cnt        <= CNT_W'(1);
                  state      <= RX;
               end
            end
            RX: begin
               if (beat) begin
                  addr <= addr_nxt;
                  data <= data_nxt;
                  cnt  <= cnt + 1'b1;
                  if (cnt == CNT_W'(ADDR_W - 1)) begin
                     slave_ready <= 1'b0;
                     if (write_mode) begin
                        rx_done <= 1'b1;
                        state   <= WRITE;
                     end else begin
                        bit_idx     <= '0;
                        slave_valid <= 1'b1;
                        tx_data     <= rd_word[0];
                        state       <= TX;
                     end
                  end
               end
            end
            WRITE: begin
               slave_ready <= 1'b1;
               state       <= IDLE;
            end
            TX: begin
               if (master_ready) begin
                  if (bit_idx == BIT_W'(DATA_W - 1)) begin
                     slave_valid   <= 1'b0;
                     tx_data       <= 1'b0;
                     slave_tx_done <= 1'b1;
                     state         <= DONE;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx_data <= rd_shift[0];
                  end
               end
            end
            DONE: begin
               slave_ready <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               slave_ready <= 1'b0;
               slave_valid <= 1'b0;
               tx_data     <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_slave.sv
// Directed bench for serial_slave: write/read of known words, stall, backpressure,
// mid-transaction reset and simultaneous-enable cases.
module tb_serial_slave;

   logic clk;
   logic reset;
   logic read_en;
   logic write_en;
   logic master_valid;
   logic master_ready;
   logic rx_address;
   logic rx_data;
   logic rx_burst;
   logic slave_ready;
   logic slave_valid;
   logic tx_data;
   logic rx_done;
   logic slave_tx_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rxd_cnt = 0;
   int sv_cnt  = 0;
   int txbad   = 0;
   int snap_rxd;
   int snap_sv;

   serial_slave #(.ADDR_W(12), .DATA_W(8), .MEM_DEPTH(4096)) dut (
      .clk          (clk),
      .reset        (reset),
      .read_en      (read_en),
      .write_en     (write_en),
      .master_valid (master_valid),
      .master_ready (master_ready),
      .rx_address   (rx_address),
      .rx_data      (rx_data),
      .rx_burst     (rx_burst),
      .slave_ready  (slave_ready),
      .slave_valid  (slave_valid),
      .tx_data      (tx_data),
      .rx_done      (rx_done),
      .slave_tx_done(slave_tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (cyc >= 2) begin
         if (rx_done === 1'b1) rxd_cnt = rxd_cnt + 1;
         if (slave_valid === 1'b1) sv_cnt = sv_cnt + 1;
         if (slave_valid !== 1'b1 && tx_data !== 1'b0) txbad = txbad + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One beat: present bits, wait (bounded) for slave_ready, cross one rising edge.
   task automatic beat(input logic a, input logic d, input logic we, input logic re);
      int n;
      rx_address   = a;
      rx_data      = d;
      write_en     = we;
      read_en      = re;
      master_valid = 1'b1;
      n = 0;
      while (slave_ready !== 1'b1 && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("beat_wait_ready", slave_ready, 1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_write(input logic [11:0] a, input logic [7:0] d, input logic we,
                           input logic re, input int stall_at, input int stall_len,
                           input int nbeats);
      int start;
      int lat;
      start = 0;
      for (int k = 0; k < nbeats; k++) begin
         beat(a[k], (k < 8) ? d[k & 7] : rnd(), (k == 0) ? we : rnd(), (k == 0) ? re : rnd());
         if (k == 0) start = cyc;
         if (k == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               master_valid = 1'b0;
               rx_address   = rnd();
               rx_data      = rnd();
               @(posedge clk);
               @(negedge clk);
            end
         end
      end
      master_valid = 1'b0;
      write_en     = 1'b0;
      read_en      = 1'b0;
      if (nbeats < 12) return;
      lat = 0;
      while (rx_done !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("wr_latency", lat, 0);
      chk("wr_cycles", cyc - start, 11 + stall_len);
      chk("wr_ready_low", slave_ready, 0);
      @(negedge clk);
      chk("wr_pulse_end", rx_done, 0);
      chk("wr_idle_ready", slave_ready, 1);
   endtask

   task automatic do_read(input logic [11:0] a, input logic [7:0] exp, input int hold_bit,
                          input int hold_len);
      int idx;
      int held;
      int vcount;
      int holdbad;
      logic [7:0] got;
      for (int k = 0; k < 12; k++) begin
         master_ready = 1'b1;
         beat(a[k], rnd(), (k == 0) ? 1'b0 : rnd(), (k == 0) ? 1'b1 : rnd());
      end
      master_valid = 1'b0;
      write_en     = 1'b0;
      read_en      = 1'b0;
      chk("rd_first_valid", slave_valid, 1);
      idx = 0; held = 0; vcount = 0; holdbad = 0; got = '0;
      for (int t = 0; t < 40; t++) begin
         if (slave_tx_done === 1'b1) break;
         if (slave_valid === 1'b1) begin
            vcount++;
            if (idx < 8) got[idx & 7] = tx_data;
            if (idx == hold_bit && held < hold_len) begin
               if (held > 0 && tx_data !== got[idx & 7]) holdbad++;
               master_ready = 1'b0;
               held++;
            end else begin
               if (held > 0 && idx == hold_bit && tx_data !== got[idx & 7]) holdbad++;
               master_ready = 1'b1;
               idx++;
            end
         end else begin
            master_ready = 1'b1;
         end
         @(negedge clk);
      end
      chk("rd_done_pulse", slave_tx_done, 1);
      chk("rd_done_valid_low", slave_valid, 0);
      chk("rd_done_tx_zero", tx_data, 0);
      chk("rd_data", got, exp);
      chk("rd_valid_cycles", vcount, 8 + hold_len);
      chk("rd_hold_stable", holdbad, 0);
      @(negedge clk);
      chk("rd_done_end", slave_tx_done, 0);
      chk("rd_idle_ready", slave_ready, 1);
   endtask

   initial begin
      reset        = 1'b0;
      read_en      = 1'b0;
      write_en     = 1'b0;
      master_valid = 1'b0;
      master_ready = 1'b0;
      rx_address   = 1'b0;
      rx_data      = 1'b0;
      rx_burst     = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_slave_ready", slave_ready, 0);
      chk("rst_slave_valid", slave_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_rx_done", rx_done, 0);
      chk("rst_tx_done", slave_tx_done, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_slave_ready", slave_ready, 1);

      // Basic write 0xADD <- 0xBD, then back-to-back read
      rx_burst = 1'b1;
      do_write(12'hADD, 8'hBD, 1'b1, 1'b0, -1, 0, 12);
      rx_burst = 1'b0;
      snap_rxd = rxd_cnt;
      do_read(12'hADD, 8'hBD, -1, 0);
      chk("rd_no_rx_done", rxd_cnt, snap_rxd);

      // Stall of 3 cycles after the 4th address beat, then backpressure on bit 3
      do_write(12'h123, 8'h5A, 1'b1, 1'b0, 3, 3, 12);
      do_read(12'h123, 8'h5A, 3, 2);

      // Reset after beat 5 of a write aborts it
      snap_rxd = rxd_cnt;
      do_write(12'hADD, 8'h00, 1'b1, 1'b0, -1, 0, 5);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready_low", slave_ready, 0);
      chk("abort_rx_done", rx_done, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_rel_ready", slave_ready, 1);
      chk("abort_no_commit", rxd_cnt, snap_rxd);

      // Beats with neither enable are ignored in IDLE
      for (int k = 0; k < 3; k++) begin
         master_valid = 1'b1;
         rx_address   = rnd();
         rx_data      = rnd();
         @(posedge clk);
         @(negedge clk);
      end
      master_valid = 1'b0;
      do_read(12'hADD, 8'hBD, -1, 0);

      // Both enables: write wins, no tx activity
      snap_sv  = sv_cnt;
      snap_rxd = rxd_cnt;
      do_write(12'h0F0, 8'hC3, 1'b1, 1'b1, -1, 0, 12);
      chk("both_no_tx", sv_cnt, snap_sv);
      chk("both_committed", rxd_cnt, snap_rxd + 1);
      do_read(12'h0F0, 8'hC3, -1, 0);

      // Overwrite returns latest value
      do_write(12'hADD, 8'h3C, 1'b1, 1'b0, -1, 0, 12);
      do_read(12'hADD, 8'h3C, 0, 1);
      do_read(12'h123, 8'h5A, 7, 3);

      chk("tx_zero_when_invalid", txbad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_slave.md
SERIAL_SLAVE -- requirements
Module: serial_slave

Interface
REQ-001 Port list (name, direction, width, meaning) SHALL be exactly the entries REQ-002..REQ-015.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 read_en  input  1  selects read transaction when idle.
REQ-005 write_en  input  1  selects write transaction when idle.
REQ-006 master_valid  input  1  master drives a valid serial bit this cycle.
REQ-007 master_ready  input  1  master accepts read-data bits.
REQ-008 rx_address  input  1  serial address bit, LSB first.
REQ-009 rx_data  input  1  serial write-data bit, LSB first.
REQ-010 rx_burst  input  1  reserved; sampled nowhere, no functional effect.
REQ-011 slave_ready  output  1  slave accepts address/data beats.
REQ-012 slave_valid  output  1  tx_data carries a valid read bit.
REQ-013 tx_data  output  1  serial read-data bit, LSB first.
REQ-014 rx_done  output  1  one-cycle pulse: write committed to memory.
REQ-015 slave_tx_done  output  1  one-cycle pulse: last read bit transferred.
REQ-016 Parameters (name, default, meaning): ADDR_W, 12, address bits; DATA_W, 8, data bits; MEM_DEPTH, 4096, bytes of internal memory.

Function
REQ-017 Internal memory SHALL be MEM_DEPTH x DATA_W, synchronous write, contents not cleared by reset.
REQ-018 States SHALL be IDLE, RX, WRITE, TX, DONE.
REQ-019 A beat SHALL be a rising edge with master_valid=1 and slave_ready=1; slave_ready SHALL be 1 exactly in IDLE and RX.
REQ-020 IDLE: beat with write_en=1 SHALL latch write mode; beat with read_en=1 and write_en=0 SHALL latch read mode; beat with neither enable SHALL be ignored.
REQ-021 Write priority: write_en=1 and read_en=1 together SHALL start a write.
REQ-022 The starting beat SHALL capture address bit 0 (and data bit 0 in write mode) and move to RX with beat counter=1.
REQ-023 RX: beat k SHALL store rx_address into addr[k] for k<ADDR_W; in write mode rx_data into data[k] for k<DATA_W; data bits for k>=DATA_W and all rx_data in read mode ignored.
REQ-024 Cycles with master_valid=0 SHALL stall RX without losing captured bits.
REQ-025 After beat ADDR_W-1: write mode -> WRITE; read mode -> TX with bit index 0.
REQ-026 WRITE (one cycle): mem[addr]<=data, rx_done=1 that cycle, next state IDLE.
REQ-027 TX: slave_valid=1, tx_data=mem[addr][bit]; on edge with master_ready=1 bit index increments; master_ready=0 holds current bit.
REQ-028 Transfer of bit DATA_W-1 with master_ready=1 -> DONE; DONE (one cycle): slave_tx_done=1, slave_valid=0, next IDLE.
REQ-029 Enable changes after IDLE SHALL have no effect until next IDLE.
REQ-030 Read of a written address SHALL return the latest written value; write-then-read back-to-back needs no extra idle cycles.
REQ-031 tx_data SHALL be 0 whenever slave_valid=0.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, clear counters, addr, data; outputs: slave_ready=0 during reset, slave_valid=0, tx_data=0, rx_done=0, slave_tx_done=0.
REQ-033 First edge with reset=1 SHALL give IDLE with slave_ready=1; reset mid-transaction SHALL abort it without a memory write.

Verification
REQ-034 Write: write_en=1, 12 beats, address bits 1,0,1,1,1,0,1,1,0,1,0,1 (0xADD) with data 1,0,1,1,1,1,0,1 on first 8 -> rx_done pulse one cycle after beat 12, mem[0xADD]=0xBD.
REQ-035 Read: then read_en=1, write_en=0, 12 address beats 0xADD, master_ready=1 -> tx_data 1,0,1,1,1,1,0,1 with slave_valid=1 for 8 cycles, slave_tx_done pulse next cycle.
REQ-036 Stall: master_valid low 3 cycles mid-address -> same final address/data, rx_done delayed 3 cycles.
REQ-037 Backpressure: master_ready=0 for 2 cycles during TX bit 3 -> bit 3 held, total 10 valid cycles, sequence unchanged.
REQ-038 Reset asserted after beat 5 of a write -> no rx_done, memory unchanged, slave_ready=1 after reset release.
REQ-039 Both enables high at start -> write performed, no tx activity.
